event_pacer: RTL and testbench

//  Source-domain stage feeding the clock-domain strobe transfer. The transfer

---
 rtl/sat_updown_counter.sv | 44 ++++
 rtl/event_pacer.sv | 102 ++++++++++
 tb/tb_event_pacer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sat_updown_counter.sv
// Saturating up/down event counter with synchronous clear.
// Holds at all-ones when an increment cannot be absorbed, and flags the lost
// event on o_sat_drop for that cycle. A simultaneous inc and dec cancel out.
module sat_updown_counter #(
   parameter int CW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_inc,
   input  logic          i_dec,
   input  logic          i_clr,
   output logic [CW-1:0] o_count,
   output logic          o_sat_drop
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] r_count;

   // An increment at full scale with nothing leaving is an event we cannot store.
   always_comb begin
      o_sat_drop = i_inc && !i_dec && !i_clr && (r_count == CNT_MAX);
   end

   // Count register: clear wins, then net +1 / -1 with saturation at both ends.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !i_dec) begin
         if (r_count != CNT_MAX) begin
            r_count <= r_count + 1'b1;
         end
      end else if (i_dec && !i_inc) begin
         if (r_count != '0) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/event_pacer.sv
// Event pacer: accepts event strobes (possibly back-to-back), queues them as a
// count, and re-issues them as single-cycle strobes spaced at least MIN_GAP
// cycles apart so a downstream strobe synchroniser never drops one.
// Reset asserts asynchronously and releases through a two-flop synchroniser.
module event_pacer #(
   parameter int MIN_GAP = 8,
   parameter int CW      = 8
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_stb,
   input  logic          i_clear,
   output logic          o_stb,
   output logic [CW-1:0] o_pending,
   output logic          o_overflow,
   output logic          o_busy
);

   localparam int             GW       = $clog2(MIN_GAP) + 1;
   localparam logic [GW-1:0]  GAP_LOAD = GW'(MIN_GAP - 1);

   logic          r_rst_meta;
   logic          r_rst_sync;
   logic [GW-1:0] r_gap;
   logic          r_stb;
   logic          r_overflow;
   logic          w_issue;
   logic          w_inc;
   logic          w_sat_drop;
   logic [CW-1:0] w_pending;

   // Reset synchroniser: immediate assert, release aligned to i_clk.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= 1'b1;
      end else begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= r_rst_meta;
      end
   end

   // Issue when the spacing window has elapsed and there is something to send;
   // a clear suppresses issue and discards any same-cycle event.
   always_comb begin
      w_issue = (r_gap == '0) && !i_clear && ((w_pending != '0) || i_stb);
      w_inc   = i_stb && !i_clear;
   end

   sat_updown_counter #(
      .CW (CW)
   ) u_pending (
      .i_clk      (i_clk),
      .i_rst      (r_rst_sync),
      .i_inc      (w_inc),
      .i_dec      (w_issue),
      .i_clr      (i_clear),
      .o_count    (w_pending),
      .o_sat_drop (w_sat_drop)
   );

   // Gap timer: reloads on every issue, counts down otherwise; clear leaves it running.
   always_ff @(posedge i_clk or posedge r_rst_sync) begin
      if (r_rst_sync) begin
         r_gap <= '0;
      end else if (w_issue) begin
         r_gap <= GAP_LOAD;
      end else if (r_gap != '0) begin
         r_gap <= r_gap - 1'b1;
      end
   end

   // Registered paced strobe keeps inputs off any combinational output path.
   always_ff @(posedge i_clk or posedge r_rst_sync) begin
      if (r_rst_sync) begin
         r_stb <= 1'b0;
      end else begin
         r_stb <= w_issue;
      end
   end

   // Sticky overflow: set by a dropped event, cleared only by clear or reset.
   always_ff @(posedge i_clk or posedge r_rst_sync) begin
      if (r_rst_sync) begin
         r_overflow <= 1'b0;
      end else if (i_clear) begin
         r_overflow <= 1'b0;
      end else if (w_sat_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // Busy derives only from registered state.
   always_comb begin
      o_busy = (w_pending != '0) || (r_gap != '0);
   end

   assign o_stb      = r_stb;
   assign o_pending  = w_pending;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_event_pacer.sv
// Bench for event_pacer: a time-based reference model predicts the cycle of
// every paced strobe into a queue; a monitor pops and compares as pulses appear.
module tb_event_pacer;

   localparam int MIN_GAP = 8;
   localparam int CW      = 3;
   localparam int MAXP    = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          stb;
   logic          clr;
   logic          o_stb;
   logic [CW-1:0] o_pending;
   logic          o_overflow;
   logic          o_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int exp_q[$];
   int seen_q[$];

   int m_pend;
   bit m_ovf;
   bit m_have_last;
   int m_last;
   int base;

   event_pacer #(
      .MIN_GAP (MIN_GAP),
      .CW      (CW)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_stb      (stb),
      .i_clear    (clr),
      .o_stb      (o_stb),
      .o_pending  (o_pending),
      .o_overflow (o_overflow),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every o_stb pulse must match the oldest predicted pulse time.
   always @(negedge clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL o_stb_missed: expected pulse at cycle %0d, still absent at cycle %0d",
                     exp_q[0], cyc);
            void'(exp_q.pop_front());
         end
         if (o_stb) begin
            seen_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL o_stb_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
               check("o_stb_time", cyc, exp_q.pop_front());
            end
         end
      end
   end

   // One cycle: check state outputs against the model, drive inputs, advance model.
   task automatic step(input bit s, input bit c);
      bit iss;
      int e;
      @(negedge clk);
      check("pending", int'(o_pending), m_pend);
      check("overflow", int'(o_overflow), int'(m_ovf));
      check("busy", int'(o_busy),
            int'((m_pend != 0) || (m_have_last && (cyc - m_last) < MIN_GAP - 1)));
      stb = s;
      clr = c;
      e   = cyc + 1;
      iss = !c && ((m_pend > 0) || s) && (!m_have_last || (e - m_last) >= MIN_GAP);
      if (iss) begin
         exp_q.push_back(e);
         m_have_last = 1'b1;
         m_last      = e;
      end
      if (c) begin
         m_pend = 0;
         m_ovf  = 1'b0;
      end else if (s && !iss) begin
         if (m_pend == MAXP) m_ovf = 1'b1;
         else m_pend++;
      end else if (!s && iss) begin
         m_pend--;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      stb = 1'b0;
      clr = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_o_stb", int'(o_stb), 0);
      check("rst_pending", int'(o_pending), 0);
      check("rst_overflow", int'(o_overflow), 0);
      check("rst_busy", int'(o_busy), 0);
      repeat (3) @(negedge clk);
      rst         = 1'b0;
      m_pend      = 0;
      m_ovf       = 1'b0;
      m_have_last = 1'b0;
      m_last      = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      stb = 1'b0;
      clr = 1'b0;
      do_reset();
      idle(5);

      // Single event on an idle block passes straight through one cycle later.
      seen_q.delete();
      base = cyc + 1;
      step(1'b1, 1'b0);
      idle(12);
      check("single_count", seen_q.size(), 1);
      if (seen_q.size() > 0) check("single_latency", seen_q[0] - base, 1);

      // Burst of five back-to-back events.
      seen_q.delete();
      base = cyc + 1;
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("burst_peak", int'(o_pending), 4);
      idle(40);
      check("burst_count", seen_q.size(), 5);
      for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
         check("burst_time", seen_q[i] - base, 1 + MIN_GAP * i);
      end
      check("burst_drained", int'(o_pending), 0);

      // Saturation: twelve back-to-back events into a 3-bit backlog.
      repeat (12) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("sat_pending", int'(o_pending), MAXP);
      check("sat_overflow", int'(o_overflow), 1);
      idle(70);

      // Clear with a same-cycle event, then a new event inside the gap window.
      step(1'b0, 1'b1);
      idle(10);
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      check("clr_pending", int'(o_pending), 0);
      check("clr_overflow", int'(o_overflow), 0);
      step(1'b1, 1'b0);
      idle(20);

      // Reset with a backlog of five, then a quiet window.
      repeat (6) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("pre_reset_pending", int'(o_pending), 5);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         check("post_reset_quiet", int'(o_stb), 0);
      end

      // Random traffic: heavy then light, with occasional clears.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(99) < 30, $urandom_range(99) < 2);
      end
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(99) < 8, $urandom_range(199) < 1);
      end
      idle(80);
      check("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
